// File: rtl/vga_source_mux.sv
// vga_source_mux: selects or composites NUM_SRC pixel sources for the VGA pins.
// Requests ({mode_in, sel_in}) are debounced into a pending register and committed
// only on a vsync falling edge, so a source change never tears a frame.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   pix_ce              pixel strobe; pixel/sync registers advance only when high
//   sel_in, mode_in     requested source index / mode (0 exclusive, 1 overlay)
//   src_red/green/blue  packed per-source colour, source i at [i*W +: W]
//   src_opaque          per-source "pixel drawn" flag (overlay priority)
//   bg_rgb              overlay background colour {r,g,b}
//   vga_blank           forces black outside the active area
//   hsync_in, vsync_in  active-low syncs from the timing generator
//   red, green, blue    registered pixel colour
//   hsync, vsync        syncs delayed by one pix_ce to match colour
//   active_sel/mode     committed selection
//   switch_pulse        one-clk pulse on every commit
module vga_source_mux #(
  parameter int unsigned NUM_SRC      = 4,
  parameter int unsigned SEL_W        = 2,
  parameter int unsigned RED_W        = 3,
  parameter int unsigned GRN_W        = 3,
  parameter int unsigned BLU_W        = 2,
  parameter int unsigned DEBOUNCE_CYC = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pix_ce,
  input  logic [SEL_W-1:0]             sel_in,
  input  logic                         mode_in,
  input  logic [NUM_SRC*RED_W-1:0]     src_red,
  input  logic [NUM_SRC*GRN_W-1:0]     src_green,
  input  logic [NUM_SRC*BLU_W-1:0]     src_blue,
  input  logic [NUM_SRC-1:0]           src_opaque,
  input  logic [RED_W+GRN_W+BLU_W-1:0] bg_rgb,
  input  logic                         vga_blank,
  input  logic                         hsync_in,
  input  logic                         vsync_in,
  output logic [RED_W-1:0]             red,
  output logic [GRN_W-1:0]             green,
  output logic [BLU_W-1:0]             blue,
  output logic                         hsync,
  output logic                         vsync,
  output logic [SEL_W-1:0]             active_sel,
  output logic                         active_mode,
  output logic                         switch_pulse
);

  localparam int unsigned RGB_W = RED_W + GRN_W + BLU_W;
  localparam int unsigned REQ_W = SEL_W + 1;
  localparam int unsigned CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

  logic [REQ_W-1:0] request;
  logic [REQ_W-1:0] lastSample;
  logic [REQ_W-1:0] pending;
  logic [CNT_W-1:0] stableCnt;
  logic             prevVsync;
  logic             sampleStable;
  logic             requestValid;
  logic             frameEdge;
  logic [RGB_W-1:0] exclRgb;
  logic [RGB_W-1:0] ovlRgb;
  logic [RGB_W-1:0] nextRgb;

  assign request      = {mode_in, sel_in};
  assign sampleStable = (request == lastSample);
  assign requestValid = (32'(sel_in) < NUM_SRC);
  assign frameEdge    = pix_ce && prevVsync && !vsync_in;

  // Debounce: latch a request once it has been sampled unchanged DEBOUNCE_CYC times.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lastSample <= '0;
      stableCnt  <= '0;
      pending    <= '0;
    end else begin
      lastSample <= request;
      if (!sampleStable) begin
        stableCnt <= '0;
      end else if (stableCnt != CNT_MAX) begin
        stableCnt <= stableCnt + 1'b1;
      end
      if (sampleStable && (stableCnt == CNT_MAX) && requestValid) begin
        pending <= request;
      end
    end
  end

  // Commit at the frame boundary; uses pending as it stood before this clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prevVsync    <= 1'b1;
      active_sel   <= '0;
      active_mode  <= 1'b0;
      switch_pulse <= 1'b0;
    end else begin
      switch_pulse <= 1'b0;
      if (pix_ce) begin
        prevVsync <= vsync_in;
      end
      if (frameEdge && (pending != {active_mode, active_sel})) begin
        {active_mode, active_sel} <= pending;
        switch_pulse              <= 1'b1;
      end
    end
  end

  // Source selection: exclusive index, or lowest-index opaque source over background.
  always_comb begin
    logic found;
    exclRgb = '0;
    ovlRgb  = bg_rgb;
    found   = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (SEL_W'(i) == active_sel) begin
        exclRgb = {src_red[i*RED_W +: RED_W], src_green[i*GRN_W +: GRN_W],
                   src_blue[i*BLU_W +: BLU_W]};
      end
      if (src_opaque[i] && !found) begin
        ovlRgb = {src_red[i*RED_W +: RED_W], src_green[i*GRN_W +: GRN_W],
                  src_blue[i*BLU_W +: BLU_W]};
        found  = 1'b1;
      end
    end
    if (vga_blank) begin
      nextRgb = '0;
    end else if (active_mode) begin
      nextRgb = ovlRgb;
    end else begin
      nextRgb = exclRgb;
    end
  end

  // Colour and syncs register together so their alignment is preserved.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else if (pix_ce) begin
      {red, green, blue} <= nextRgb;
      hsync              <= hsync_in;
      vsync              <= vsync_in;
    end
  end

endmodule

// File: tb/tb_vga_source_mux.sv
module tb_vga_source_mux;

  localparam int unsigned NUM_SRC = 5;
  localparam int unsigned SEL_W   = 3;
  localparam int unsigned RED_W   = 3;
  localparam int unsigned GRN_W   = 3;
  localparam int unsigned BLU_W   = 2;
  localparam int unsigned DEB     = 16;
  localparam int unsigned RGB_W   = RED_W + GRN_W + BLU_W;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     pix_ce = 1'b0;
  logic [SEL_W-1:0]         sel_in = '0;
  logic                     mode_in = 1'b0;
  logic [NUM_SRC*RED_W-1:0] src_red = '0;
  logic [NUM_SRC*GRN_W-1:0] src_green = '0;
  logic [NUM_SRC*BLU_W-1:0] src_blue = '0;
  logic [NUM_SRC-1:0]       src_opaque = '0;
  logic [RGB_W-1:0]         bg_rgb = '0;
  logic                     vga_blank = 1'b0;
  logic                     hsync_in = 1'b1;
  logic                     vsync_in = 1'b1;
  logic [RED_W-1:0]         red;
  logic [GRN_W-1:0]         green;
  logic [BLU_W-1:0]         blue;
  logic                     hsync;
  logic                     vsync;
  logic [SEL_W-1:0]         active_sel;
  logic                     active_mode;
  logic                     switch_pulse;

  // Reference state: per-source colours and the selection the bench expects committed.
  logic [RED_W-1:0]   rArr [NUM_SRC];
  logic [GRN_W-1:0]   gArr [NUM_SRC];
  logic [BLU_W-1:0]   bArr [NUM_SRC];
  logic [NUM_SRC-1:0] opq;
  logic [RGB_W-1:0]   bg;
  int                 expSel = 0;
  logic               expMode = 1'b0;

  int checks = 0;
  int errors = 0;
  int pulseCount = 0;

  vga_source_mux #(
    .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .RED_W(RED_W), .GRN_W(GRN_W),
    .BLU_W(BLU_W), .DEBOUNCE_CYC(DEB)
  ) dut (
    .clk(clk), .rst(rst), .pix_ce(pix_ce), .sel_in(sel_in), .mode_in(mode_in),
    .src_red(src_red), .src_green(src_green), .src_blue(src_blue),
    .src_opaque(src_opaque), .bg_rgb(bg_rgb), .vga_blank(vga_blank),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .red(red), .green(green),
    .blue(blue), .hsync(hsync), .vsync(vsync), .active_sel(active_sel),
    .active_mode(active_mode), .switch_pulse(switch_pulse)
  );

  always #5 clk = ~clk;

  // Counts clk cycles in which switch_pulse is high.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (switch_pulse === 1'b1) pulseCount++;
    end
  end

  function automatic logic [RGB_W-1:0] modelRgb(input logic mode, input int sel, input logic blank);
    if (blank) return '0;
    if (!mode) return {rArr[sel], gArr[sel], bArr[sel]};
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (opq[i]) return {rArr[i], gArr[i], bArr[i]};
    end
    return bg;
  endfunction

  task automatic applySrc();
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      src_red[i*RED_W +: RED_W]   = rArr[i];
      src_green[i*GRN_W +: GRN_W] = gArr[i];
      src_blue[i*BLU_W +: BLU_W]  = bArr[i];
    end
    src_opaque = opq;
    bg_rgb     = bg;
  endtask

  task automatic randSrc();
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      rArr[i] = RED_W'($urandom);
      gArr[i] = GRN_W'($urandom);
      bArr[i] = BLU_W'($urandom);
    end
    opq = NUM_SRC'($urandom);
    bg  = RGB_W'($urandom);
    applySrc();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One pixel strobe with the given syncs; returns at the following negedge.
  task automatic doPix(input logic vs, input logic hs);
    @(negedge clk);
    vsync_in = vs;
    hsync_in = hs;
    pix_ce   = 1'b1;
    @(negedge clk);
    pix_ce   = 1'b0;
  endtask

  task automatic test_reset();
    idle(2);
    if ({red, green, blue} !== '0) begin
      errors++; $display("FAIL reset_rgb: got %0h want 0", {red, green, blue});
    end
    checks++;
    if ({hsync, vsync} !== 2'b11) begin
      errors++; $display("FAIL reset_sync: got %b want 11", {hsync, vsync});
    end
    checks++;
    if ({active_mode, active_sel} !== '0 || switch_pulse !== 1'b0) begin
      errors++; $display("FAIL reset_active: got %0h/%b want 0/0", {active_mode, active_sel}, switch_pulse);
    end
    checks++;
    randSrc();
    rArr[0] = 3'd7;
    applySrc();
    rst = 1'b0;
    doPix(1'b1, 1'b1);
    if (red !== 3'd7 || {red, green, blue} !== modelRgb(1'b0, 0, 1'b0)) begin
      errors++; $display("FAIL reset_first_pix: got %0h want %0h", {red, green, blue}, modelRgb(1'b0, 0, 1'b0));
    end
    checks++;
  endtask

  task automatic test_exclusive_switch();
    int p0;
    sel_in = 3'd2;
    idle(20);
    doPix(1'b1, 1'b1);
    doPix(1'b1, 1'b1);
    if (active_sel !== 3'd0 || {red, green, blue} !== modelRgb(1'b0, 0, 1'b0)) begin
      errors++; $display("FAIL excl_midframe: got sel %0d rgb %0h want sel 0 rgb %0h",
                         active_sel, {red, green, blue}, modelRgb(1'b0, 0, 1'b0));
    end
    checks++;
    p0 = pulseCount;
    doPix(1'b0, 1'b1);
    expSel = 2;
    if (active_sel !== SEL_W'(expSel) || pulseCount - p0 !== 1) begin
      errors++; $display("FAIL excl_commit: got sel %0d pulses %0d want sel 2 pulses 1", active_sel, pulseCount - p0);
    end
    checks++;
    doPix(1'b0, 1'b0);
    if ({red, green, blue} !== modelRgb(1'b0, expSel, 1'b0) || {hsync, vsync} !== 2'b00) begin
      errors++; $display("FAIL excl_newsrc: got rgb %0h sync %b want rgb %0h sync 00",
                         {red, green, blue}, {hsync, vsync}, modelRgb(1'b0, expSel, 1'b0));
    end
    checks++;
    doPix(1'b1, 1'b1);
  endtask

  task automatic test_glitch();
    int p0;
    p0 = pulseCount;
    for (int k = 0; k < 4; k++) begin
      logic [SEL_W:0] g;
      do g = (SEL_W+1)'($urandom); while (g == {1'b0, 3'd2});
      {mode_in, sel_in} = g;
      idle(int'($urandom_range(1, DEB - 1)));
      {mode_in, sel_in} = {1'b0, 3'd2};
      idle(20);
    end
    for (int f = 0; f < 3; f++) begin
      doPix(1'b1, 1'b1);
      doPix(1'b0, 1'b1);
      idle(3);
    end
    doPix(1'b1, 1'b1);
    if (pulseCount - p0 !== 0 || active_sel !== SEL_W'(expSel) || active_mode !== expMode) begin
      errors++; $display("FAIL glitch: got pulses %0d sel %0d mode %b want 0/%0d/%b",
                         pulseCount - p0, active_sel, active_mode, expSel, expMode);
    end
    checks++;
  endtask

  task automatic test_overlay();
    logic [RGB_W-1:0] exp;
    logic hs;
    mode_in = 1'b1;
    idle(20);
    doPix(1'b1, 1'b1);
    doPix(1'b0, 1'b1);
    expMode = 1'b1;
    doPix(1'b1, 1'b1);
    if (active_mode !== 1'b1 || active_sel !== SEL_W'(expSel)) begin
      errors++; $display("FAIL ovl_commit: got mode %b sel %0d want 1/%0d", active_mode, active_sel, expSel);
    end
    checks++;
    randSrc();
    opq = 5'b01010;
    rArr[1] = 3'd7; gArr[1] = 3'd0; bArr[1] = 2'd0;
    rArr[3] = 3'd0; gArr[3] = 3'd7; bArr[3] = 2'd0;
    applySrc();
    doPix(1'b1, 1'b1);
    if ({red, green, blue} !== {3'd7, 3'd0, 2'd0}) begin
      errors++; $display("FAIL ovl_priority: got %0h want e0", {red, green, blue});
    end
    checks++;
    opq = '0;
    bg  = 8'h03;
    applySrc();
    doPix(1'b1, 1'b1);
    if ({red, green, blue} !== 8'h03) begin
      errors++; $display("FAIL ovl_bg: got %0h want 03", {red, green, blue});
    end
    checks++;
    vga_blank = 1'b1;
    doPix(1'b1, 1'b1);
    if ({red, green, blue} !== 8'h00) begin
      errors++; $display("FAIL ovl_blank: got %0h want 00", {red, green, blue});
    end
    checks++;
    for (int k = 0; k < 16; k++) begin
      randSrc();
      vga_blank = ($urandom_range(0, 3) == 0);
      hs = 1'($urandom);
      exp = modelRgb(1'b1, expSel, vga_blank);
      doPix(1'b1, hs);
      if ({red, green, blue} !== exp || hsync !== hs) begin
        errors++; $display("FAIL ovl_random: iter %0d got rgb %0h hs %b want %0h %b",
                           k, {red, green, blue}, hsync, exp, hs);
      end
      checks++;
    end
    exp = {red, green, blue};
    randSrc();
    vga_blank = 1'b0;
    idle(3);
    if ({red, green, blue} !== exp) begin
      errors++; $display("FAIL pix_hold: got %0h want %0h", {red, green, blue}, exp);
    end
    checks++;
  endtask

  task automatic test_invalid_sel();
    int p0;
    p0 = pulseCount;
    mode_in = 1'b0;
    sel_in  = SEL_W'($urandom_range(NUM_SRC, (1 << SEL_W) - 1));
    idle(100);
    doPix(1'b1, 1'b1);
    doPix(1'b0, 1'b1);
    doPix(1'b1, 1'b1);
    if (pulseCount - p0 !== 0 || active_mode !== expMode || active_sel !== SEL_W'(expSel)) begin
      errors++; $display("FAIL invalid_sel: got pulses %0d mode %b sel %0d want 0/%b/%0d",
                         pulseCount - p0, active_mode, active_sel, expMode, expSel);
    end
    checks++;
  endtask

  task automatic test_coincide();
    int p0;
    doPix(1'b1, 1'b1);
    p0 = pulseCount;
    {mode_in, sel_in} = {1'b0, 3'd1};
    idle(DEB - 1);
    doPix(1'b0, 1'b1);
    if (pulseCount - p0 !== 0 || active_mode !== expMode) begin
      errors++; $display("FAIL coincide_defer: got pulses %0d mode %b want 0/%b", pulseCount - p0, active_mode, expMode);
    end
    checks++;
    doPix(1'b1, 1'b1);
    doPix(1'b0, 1'b1);
    expSel = 1; expMode = 1'b0;
    if (pulseCount - p0 !== 1 || active_mode !== expMode || active_sel !== SEL_W'(expSel)) begin
      errors++; $display("FAIL coincide_next: got pulses %0d mode %b sel %0d want 1/0/1",
                         pulseCount - p0, active_mode, active_sel);
    end
    checks++;
    doPix(1'b1, 1'b1);
    p0 = pulseCount;
    sel_in = 3'd4;
    idle(DEB);
    doPix(1'b0, 1'b1);
    expSel = 4;
    if (pulseCount - p0 !== 1 || active_sel !== SEL_W'(expSel)) begin
      errors++; $display("FAIL latch_latency: got pulses %0d sel %0d want 1/4", pulseCount - p0, active_sel);
    end
    checks++;
    doPix(1'b1, 1'b1);
  endtask

  task automatic test_reset_mid_frame();
    int p0;
    randSrc();
    doPix(1'b1, 1'b0);
    doPix(1'b1, 1'b0);
    rst = 1'b1;
    #1;
    if (active_sel !== '0 || active_mode !== 1'b0 || {red, green, blue} !== '0 || {hsync, vsync} !== 2'b11) begin
      errors++; $display("FAIL reset_async: got sel %0d mode %b rgb %0h sync %b want 0/0/0/11",
                         active_sel, active_mode, {red, green, blue}, {hsync, vsync});
    end
    checks++;
    expSel = 0; expMode = 1'b0;
    {mode_in, sel_in} = '0;
    vsync_in = 1'b0;
    hsync_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    p0 = pulseCount;
    doPix(1'b0, 1'b0);
    if ({hsync, vsync} !== 2'b00 || {red, green, blue} !== modelRgb(1'b0, 0, 1'b0) || pulseCount - p0 !== 0) begin
      errors++; $display("FAIL reset_resume: got sync %b rgb %0h pulses %0d want 00 %0h 0",
                         {hsync, vsync}, {red, green, blue}, pulseCount - p0, modelRgb(1'b0, 0, 1'b0));
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_exclusive_switch();
    test_glitch();
    test_overlay();
    test_invalid_sel();
    test_coincide();
    test_reset_mid_frame();
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_source_mux.md
# vga_source_mux

Parametrised VGA pixel-source selector and compositor for the demo top level. It sits between the `vga_controller_640_60` timing generator and the board RGB/sync pins, and chooses among NUM_SRC drawing engines (circle, ball-on-line, maze, cursor, …). Source and mode changes are debounced and committed only at a frame boundary, so the display never tears. An overlay mode composites all sources by fixed priority over a background colour.

## Interface
Parameters:
- NUM_SRC, 4, number of pixel sources (2..16)
- SEL_W, 2, width of source index; must satisfy 2^SEL_W >= NUM_SRC
- RED_W, 3 / GRN_W, 3 / BLU_W, 2, colour component widths
- DEBOUNCE_CYC, 16, consecutive clk cycles a request must be stable before it is accepted (>= 1)

Ports:
- clk  in  1  system clock; the only clock
- rst  in  1  asynchronous, active-high reset
- pix_ce  in  1  one-clk pixel strobe (VGA clock-divider rate); all pixel/sync registers advance only when high
- sel_in  in  SEL_W  requested source index (exclusive mode)
- mode_in  in  1  requested mode: 0 = exclusive, 1 = overlay
- src_red  in  NUM_SRC*RED_W  per-source red, source i at bits [i*RED_W +: RED_W]
- src_green  in  NUM_SRC*GRN_W  same packing
- src_blue  in  NUM_SRC*BLU_W  same packing
- src_opaque  in  NUM_SRC  per-source "pixel drawn" flag
- bg_rgb  in  RED_W+GRN_W+BLU_W  background colour {r,g,b}
- vga_blank  in  1  high outside the active area
- hsync_in / vsync_in  in  1  active-low syncs from the timing generator
- red / green / blue  out  RED_W / GRN_W / BLU_W  registered pixel colour
- hsync / vsync  out  1  syncs delayed to match pixel latency
- active_sel  out  SEL_W  committed source index
- active_mode  out  1  committed mode
- switch_pulse  out  1  one-clk pulse on every commit

## Operation
- Request debounce, every clk: if {mode_in,sel_in} differs from the last sample, reset the stability counter to 0; otherwise increment, saturating. When the counter reaches DEBOUNCE_CYC-1, latch the sample into `pending`. A request with sel_in >= NUM_SRC is never latched, and `pending` keeps its old value.
- Frame boundary: a falling edge of vsync_in, detected on pix_ce cycles (the registered previous vsync_in is 1 and the current value is 0).
- Commit: at a frame boundary, if `pending` != {active_mode,active_sel}, copy `pending` into active and pulse switch_pulse for that clk. Otherwise do nothing.
- Pixel select, uses the committed values only:
  - Exclusive: output the colour of source active_sel, ignoring src_opaque.
  - Overlay: output the colour of the lowest index i with src_opaque[i] = 1. If no source is opaque, output bg_rgb.
  - vga_blank = 1 forces the colour to all zeros in both modes.
- A source change only ever takes effect from the first pixel of a new frame.

## Timing
- Reset values: red/green/blue = 0, hsync = vsync = 1, active_sel = 0, active_mode = 0, switch_pulse = 0, pending = 0, stability counter = 0, previous-vsync register = 1.
- Pixel latency is exactly one pix_ce:
  - colour, hsync and vsync register together on pix_ce;
  - they hold between strobes;
  - sync alignment relative to colour is preserved.
- Request latency: a stable request is latched DEBOUNCE_CYC clk cycles after it first appears. It is committed at the next frame boundary after that.
- Simultaneous events:
  - If `pending` is updated in the same clk as a frame boundary, the commit uses the value pending held before that clk. The new value waits for the next boundary.
  - A request that toggles faster than DEBOUNCE_CYC is never latched.
- Reset mid-frame: all state returns to reset values immediately (asynchronous). After release, display resumes with source 0 exclusive at the next pix_ce.
- switch_pulse lasts exactly one clk, regardless of pix_ce.

## Test plan
- Reset with NUM_SRC=4, source 0 red=7, sel_in=0 -> after release and one pix_ce, red=7. During reset, hsync=vsync=1 and outputs are 0.
- sel_in 0->2 held 16 clk mid-frame -> active_sel stays 0 until the next vsync falling edge. It then becomes 2, with one switch_pulse. The following pix_ce outputs source 2's colour.
- sel_in glitches to 3 for 10 clk (DEBOUNCE_CYC=16), then returns -> no pending change, no switch_pulse, active_sel unchanged across 3 frames.
- Overlay mode with opaque=4'b1010, src1 = {7,0,0}, src3 = {0,7,0} -> output {7,0,0}. With opaque=0 and bg_rgb = 8'h03 -> output {0,0,3}. With vga_blank=1 -> {0,0,0}.
- sel_in=5 with NUM_SRC=4, held 100 clk -> pending unchanged and no commit. Pending update coinciding with a vsync edge -> commit deferred exactly one frame.
- Assert rst mid-frame with active_sel=2 -> active_sel=0 and outputs 0 immediately. Sync outputs resume matching vsync_in/hsync_in one pix_ce later.
